// File: rtl/writeback_arbiter.sv
// Register-file write-port arbiter: port A (ALU/load) always wins, port B
// (long-latency unit) results queue in a small FIFO and fill idle slots.
module writeback_arbiter #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lu_valid,
  output logic            lu_ready,
  input  logic [4:0]      lu_rd,
  input  logic [XLEN-1:0] lu_data,
  output logic            write_enable,
  output logic [4:0]      write_reg,
  output logic [XLEN-1:0] write_data,
  output logic [31:0]     pending_mask
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [DEPTH-1:0] live;
  logic [4:0]       ent_rd   [DEPTH];
  logic [XLEN-1:0]  ent_data [DEPTH];
  logic [PW-1:0]    head, tail;
  logic [PW:0]      count;

  logic a_req, xfer, empty, pop, bypass, discard, push;

  assign lu_ready = !reset && (count != FULL);
  assign xfer     = lu_valid && lu_ready;
  assign a_req    = alu_valid && (alu_rd != 5'd0);
  assign empty    = (count == '0);
  assign pop      = !a_req && !empty;
  assign bypass   = !a_req && empty && xfer && (lu_rd != 5'd0);
  // A port-B result to the same register as a concurrent port-A write is stale.
  assign discard  = xfer && ((lu_rd == 5'd0) || (a_req && (lu_rd == alu_rd)));
  assign push     = xfer && !bypass && !discard;

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live[i]) pending_mask[ent_rd[i]] = 1'b1;
    end
    pending_mask[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      live         <= '0;
      write_enable <= 1'b0;
      write_reg    <= '0;
      write_data   <= '0;
    end else begin
      // Port A is younger than everything queued, so it supersedes matching entries.
      for (int i = 0; i < DEPTH; i++) begin
        if (a_req && (ent_rd[i] == alu_rd)) live[i] <= 1'b0;
      end
      if (pop) begin
        live[head] <= 1'b0;
        head       <= head + PW'(1);
      end
      if (push) begin
        live[tail]     <= 1'b1;
        ent_rd[tail]   <= lu_rd;
        ent_data[tail] <= lu_data;
        tail           <= tail + PW'(1);
      end
      count <= count + (PW+1)'(push) - (PW+1)'(pop);

      if (a_req) begin
        write_enable <= 1'b1;
        write_reg    <= alu_rd;
        write_data   <= alu_data;
      end else if (pop) begin
        write_enable <= live[head];
        if (live[head]) begin
          write_reg  <= ent_rd[head];
          write_data <= ent_data[head];
        end
      end else if (bypass) begin
        write_enable <= 1'b1;
        write_reg    <= lu_rd;
        write_data   <= lu_data;
      end else begin
        write_enable <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: hand-computed vector table, directed reset
// sequence, and randomized traffic against a queue-based reference model.
module tb_writeback_arbiter;
  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            lu_valid;
  logic            lu_ready;
  logic [4:0]      lu_rd;
  logic [XLEN-1:0] lu_data;
  logic            write_enable;
  logic [4:0]      write_reg;
  logic [XLEN-1:0] write_data;
  logic [31:0]     pending_mask;

  always #5 clk = ~clk;

  writeback_arbiter #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data),
    .write_enable(write_enable), .write_reg(write_reg), .write_data(write_data),
    .pending_mask(pending_mask)
  );

  typedef struct {
    logic        rst;
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adata;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ldata;
    logic        ewe;
    logic [4:0]  ereg;
    logic [31:0] edata;
    logic [31:0] emask;
    logic        erdy;
  } vec_t;

  typedef struct {
    logic        live;
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  vec_t vecs[24];

  // Reference model: a plain queue of results plus the last write seen.
  ent_t        mq[$];
  logic        m_we;
  logic [4:0]  m_reg;
  logic [31:0] m_data;

  int total = 0;
  int bad   = 0;

  function automatic logic [31:0] modelMask();
    logic [31:0] m = '0;
    foreach (mq[i]) if (mq[i].live) m[mq[i].rd] = 1'b1;
    return m;
  endfunction

  task automatic modelStep();
    logic rdy, xfer, areq, byp;
    ent_t h;
    rdy  = !reset && (mq.size() != DEPTH);
    xfer = lu_valid && rdy;
    areq = alu_valid && (alu_rd != 5'd0);
    byp  = 1'b0;
    if (reset) begin
      mq.delete();
      m_we = 1'b0; m_reg = '0; m_data = '0;
    end else begin
      if (areq) foreach (mq[i]) if (mq[i].rd == alu_rd) mq[i].live = 1'b0;
      if (areq) begin
        m_we = 1'b1; m_reg = alu_rd; m_data = alu_data;
      end else if (mq.size() != 0) begin
        h = mq.pop_front();
        m_we = h.live;
        if (h.live) begin m_reg = h.rd; m_data = h.data; end
      end else if (xfer && lu_rd != 5'd0) begin
        byp = 1'b1;
        m_we = 1'b1; m_reg = lu_rd; m_data = lu_data;
      end else begin
        m_we = 1'b0;
      end
      if (xfer && !byp && lu_rd != 5'd0 && !(areq && lu_rd == alu_rd))
        mq.push_back('{1'b1, lu_rd, lu_data});
    end
  endtask

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, advance the model, and sample just after the edge.
  task automatic applyStimulus(input logic rst, input logic av, input logic [4:0] ard,
                               input logic [31:0] adata, input logic lv,
                               input logic [4:0] lrd, input logic [31:0] ldata);
    reset = rst; alu_valid = av; alu_rd = ard; alu_data = adata;
    lu_valid = lv; lu_rd = lrd; lu_data = ldata;
    modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    compare({tag, ".we"},   {31'd0, write_enable}, {31'd0, m_we});
    compare({tag, ".reg"},  {27'd0, write_reg},    {27'd0, m_reg});
    compare({tag, ".data"}, write_data,            m_data);
    compare({tag, ".mask"}, pending_mask,          modelMask());
    compare({tag, ".rdy"},  {31'd0, lu_ready},     {31'd0, (!reset && mq.size() != DEPTH)});
  endtask

  function automatic vec_t mk(input logic rst, input logic av, input logic [4:0] ard,
                              input logic [31:0] adata, input logic lv, input logic [4:0] lrd,
                              input logic [31:0] ldata, input logic ewe, input logic [4:0] ereg,
                              input logic [31:0] edata, input logic [31:0] emask, input logic erdy);
    vec_t v;
    v.rst = rst; v.av = av; v.ard = ard; v.adata = adata;
    v.lv = lv; v.lrd = lrd; v.ldata = ldata;
    v.ewe = ewe; v.ereg = ereg; v.edata = edata; v.emask = emask; v.erdy = erdy;
    return v;
  endfunction

  initial begin
    reset = 1'b1; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lu_valid = 1'b0; lu_rd = '0; lu_data = '0;
    m_we = 1'b0; m_reg = '0; m_data = '0;

    // Expected outputs after each edge, derived by hand.
    vecs[0]  = mk(1, 0, 0,  32'h0,        0, 0, 32'h0,        0, 0,  32'h0,        32'h0,   0);
    vecs[1]  = mk(0, 1, 5,  32'hDEADBEEF, 0, 0, 32'h0,        1, 5,  32'hDEADBEEF, 32'h0,   1);
    vecs[2]  = mk(0, 1, 0,  32'h55,       0, 0, 32'h0,        0, 5,  32'hDEADBEEF, 32'h0,   1);
    vecs[3]  = mk(0, 0, 0,  32'h0,        1, 7, 32'h12345678, 1, 7,  32'h12345678, 32'h0,   1);
    vecs[4]  = mk(0, 0, 0,  32'h0,        0, 0, 32'h0,        0, 7,  32'h12345678, 32'h0,   1);
    vecs[5]  = mk(0, 1, 10, 32'hA0,       1, 1, 32'h101,      1, 10, 32'hA0,       32'h2,   1);
    vecs[6]  = mk(0, 1, 11, 32'hA1,       1, 2, 32'h102,      1, 11, 32'hA1,       32'h6,   1);
    vecs[7]  = mk(0, 1, 12, 32'hA2,       1, 3, 32'h103,      1, 12, 32'hA2,       32'hE,   1);
    vecs[8]  = mk(0, 1, 13, 32'hA3,       1, 4, 32'h104,      1, 13, 32'hA3,       32'h1E,  0);
    vecs[9]  = mk(0, 1, 14, 32'hA4,       1, 5, 32'h105,      1, 14, 32'hA4,       32'h1E,  0);
    vecs[10] = mk(0, 1, 15, 32'hA5,       0, 0, 32'h0,        1, 15, 32'hA5,       32'h1E,  0);
    vecs[11] = mk(0, 0, 0,  32'h0,        0, 0, 32'h0,        1, 1,  32'h101,      32'h1C,  1);
    vecs[12] = mk(0, 0, 0,  32'h0,        0, 0, 32'h0,        1, 2,  32'h102,      32'h18,  1);
    vecs[13] = mk(0, 0, 0,  32'h0,        0, 0, 32'h0,        1, 3,  32'h103,      32'h10,  1);
    vecs[14] = mk(0, 0, 0,  32'h0,        0, 0, 32'h0,        1, 4,  32'h104,      32'h0,   1);
    vecs[15] = mk(0, 0, 0,  32'h0,        0, 0, 32'h0,        0, 4,  32'h104,      32'h0,   1);
    vecs[16] = mk(0, 1, 20, 32'h20,       1, 9, 32'h1,        1, 20, 32'h20,       32'h200, 1);
    vecs[17] = mk(0, 1, 9,  32'h2,        0, 0, 32'h0,        1, 9,  32'h2,        32'h0,   1);
    vecs[18] = mk(0, 0, 0,  32'h0,        0, 0, 32'h0,        0, 9,  32'h2,        32'h0,   1);
    vecs[19] = mk(0, 0, 0,  32'h0,        0, 0, 32'h0,        0, 9,  32'h2,        32'h0,   1);
    vecs[20] = mk(0, 1, 3,  32'h33,       1, 3, 32'h44,       1, 3,  32'h33,       32'h0,   1);
    vecs[21] = mk(0, 0, 0,  32'h0,        0, 0, 32'h0,        0, 3,  32'h33,       32'h0,   1);
    vecs[22] = mk(0, 0, 0,  32'h0,        1, 0, 32'h99,       0, 3,  32'h33,       32'h0,   1);
    vecs[23] = mk(0, 0, 0,  32'h0,        0, 0, 32'h0,        0, 3,  32'h33,       32'h0,   1);

    for (int i = 0; i < 24; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].av, vecs[i].ard, vecs[i].adata,
                    vecs[i].lv, vecs[i].lrd, vecs[i].ldata);
      compare($sformatf("vec%0d.we", i),   {31'd0, write_enable}, {31'd0, vecs[i].ewe});
      compare($sformatf("vec%0d.reg", i),  {27'd0, write_reg},    {27'd0, vecs[i].ereg});
      compare($sformatf("vec%0d.data", i), write_data,            vecs[i].edata);
      compare($sformatf("vec%0d.mask", i), pending_mask,          vecs[i].emask);
      compare($sformatf("vec%0d.rdy", i),  {31'd0, lu_ready},     {31'd0, vecs[i].erdy});
    end

    // Reset while three results are queued behind a busy port A.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 5'(16 + i), 32'h600 + i, 1, 5'(21 + i), 32'h700 + i);
      checkOutput($sformatf("fill%0d", i));
    end
    compare("fill.mask", pending_mask, 32'h00E0_0000);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    compare("rst.we",   {31'd0, write_enable}, 32'd0);
    compare("rst.reg",  {27'd0, write_reg},    32'd0);
    compare("rst.data", write_data,            32'd0);
    compare("rst.mask", pending_mask,          32'd0);
    compare("rst.rdy",  {31'd0, lu_ready},     32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    compare("post_rst.rdy",  {31'd0, lu_ready},     32'd1);
    compare("post_rst.we",   {31'd0, write_enable}, 32'd0);
    compare("post_rst.mask", pending_mask,          32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput($sformatf("post_rst_idle%0d", i));
    end

    // Randomized traffic with small register range to exercise kills and pointer wrap.
    for (int i = 0; i < 400; i++) begin
      logic av, lv;
      logic [4:0] ard, lrd;
      av  = ($urandom_range(0, 99) < ((i % 80) < 40 ? 70 : 25));
      lv  = ($urandom_range(0, 99) < 60);
      ard = 5'($urandom_range(0, 7));
      lrd = 5'($urandom_range(0, 7));
      applyStimulus(0, av, ard, $urandom, lv, lrd, $urandom);
      checkOutput($sformatf("rnd%0d", i));
    end
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput($sformatf("drain%0d", i));
    end
    compare("drain.mask", pending_mask, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

Merges register-file write traffic from the in-order ALU/load pipeline (port A) and a long-latency execution unit such as the divider (port B) onto the single write port of the 32x32 register file. Port A never stalls and always wins; port B results are buffered in a small FIFO and drained into idle write slots. The block also reports a per-register pending mask to the hazard unit, and it discards queued port-B results that a younger port-A write has superseded.

## Interface
- DEPTH, 4, port-B FIFO entries; power of two, at least 2
- XLEN, 32, data width
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- alu_valid  input  1  port A write request this cycle; cannot be back-pressured
- alu_rd  input  5  port A destination register
- alu_data  input  XLEN  port A result
- lu_valid  input  1  port B result valid
- lu_ready  output  1  port B can accept this cycle
- lu_rd  input  5  port B destination register
- lu_data  input  XLEN  port B result
- write_enable  output  1  register-file write enable (registered)
- write_reg  output  5  register-file write address (registered)
- write_data  output  XLEN  register-file write data (registered)
- pending_mask  output  32  bit r is set while any live FIFO entry targets register r; bit 0 is always 0

## Operation
- Port A effective request: alu_valid && alu_rd != 0. A request with rd 0 is ignored and leaves the write slot free.
- Port B handshake: a transfer occurs when lu_valid && lu_ready.
  - lu_ready = !reset && (count != DEPTH). It is combinational from registered state and never depends on lu_valid or port A.
  - A transferred entry with lu_rd == 0 is consumed and discarded, not enqueued.
- FIFO: circular buffer with head and tail pointers and a count.
  - Each entry holds {live, rd, data}.
  - Pointers wrap modulo DEPTH.
- Kill rule (port A is younger than any port-B result):
  - On an effective port A request with rd r, every FIFO entry with rd == r has its live bit cleared in the same edge.
  - A port-B transfer in the same cycle with lu_rd == r is consumed and discarded.
- Slot selection each cycle, in priority order:
  1. Effective port A request: the output register loads {1, alu_rd, alu_data}.
  2. Else, FIFO non-empty: pop the head.
     - Live head: the output register loads {1, rd, data}.
     - Dead head: write_enable goes to 0; the slot is consumed without a write.
  3. Else, FIFO empty and a port-B transfer with rd != 0: bypass. The output register loads {1, lu_rd, lu_data} and nothing is enqueued.
  4. Else: write_enable goes to 0.
- Any port-B transfer that is not bypassed and not discarded is enqueued at the tail with live=1. This happens in the same edge as a pop, if any.
- pending_mask is the OR over live FIFO entries of a one-hot decode of rd, computed from registered state. It excludes the output register and in-flight inputs.
- write_reg and write_data hold their previous values when write_enable is 0.

## Timing
- Latency:
  - Port A: write_enable/write_reg/write_data are valid the cycle after alu_valid.
  - Port B bypass: outputs valid the cycle after the transfer.
  - Queued port-B entry: written no earlier than the cycle after it reaches the head in an idle slot.
- Throughput: one register-file write per cycle maximum. With port A continuously active the FIFO never drains. There is no starvation guarantee.
- Full FIFO: lu_ready is 0 even if a pop happens in that cycle; ready returns the cycle after count drops.
- Simultaneous enqueue and pop on a non-empty FIFO leaves count unchanged.
- Dead entries occupy capacity until popped.
- Reset values:
  - write_enable=0, write_reg=0, write_data=0
  - pending_mask=0, lu_ready=0 during the reset cycle
  - count=0, head=tail=0, all live bits cleared
- Reset mid-operation: all queued results are lost, with no write issued. lu_ready is 1 on the first cycle after reset deasserts.

## Test plan
- Port A only: alu_valid=1, rd=5, data=0xDEADBEEF at cycle 0 -> write_enable=1, write_reg=5, write_data=0xDEADBEEF at cycle 1; rd=0 request -> write_enable=0.
- Bypass: idle port A, lu transfer rd=7, data=0x12345678 into an empty FIFO -> write at the next cycle, pending_mask stays 0.
- Contention: port A active on 6 consecutive cycles while lu sends rd=1..4.
  - Entries queue; pending_mask=0x1E; lu_ready=0 after the fourth accept.
  - Once A idles, writes drain in order r1..r4 on consecutive cycles.
- Kill: queue rd=9 data=0x1 behind busy port A, then port A writes rd=9 data=0x2.
  - Only 0x2 reaches r9.
  - The dead head pops with write_enable=0.
  - pending_mask bit 9 clears the cycle after the port-A accept.
- Wrap-around: 3×DEPTH port-B transfers under random port-A activity -> every live entry is written exactly once, in order; no loss or duplication across pointer wrap.
- Reset mid-drain: assert reset with 3 entries queued -> no further writes; all outputs 0; lu_ready=0 during reset and 1 on the first cycle after.
